fp_rnd_pipe: RTL and testbench

// - Rounding/packing stage directly downstream of fp_fma: consumes the fp_rnd record (sig, expo, mant, grs, fmt, rm, snan, qnan, dbz, infs, zero, diff).
// - Produces an IEEE-754 binary32 result and the fflags word NV,DZ,OF,UF,NX.
// - Two-stage pipeline with a valid/ready handshake, so FPU writeback backpressure stalls rounding without losing operands.

---
 rtl/fp_rnd_pipe_pkg.sv | 91 +++++++++
 rtl/fp_rnd_pipe.sv | 153 +++++++++++++++
 tb/tb_fp_rnd_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_rnd_pipe_pkg.sv
// Shared types, constants and the rounding-increment helper for the binary32
// rounding/packing pipeline that sits behind the fused multiply-add.
package fp_rnd_pipe_pkg;

    localparam int EXP_W  = 11;
    localparam int MANT_W = 25;
    localparam int FRAC_W = 23;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0]      CANON_NAN = 32'h7FC00000;
    localparam logic [30:0]      MAX_FIN   = 31'h7F7FFFFF;
    localparam logic [7:0]       EXP_INF   = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_OVF   = EXP_W'(255);

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic              sig;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
        logic [1:0]        rema;
        logic [2:0]        grs;
        logic [1:0]        fmt;
        logic [2:0]        rm;
        logic              snan;
        logic              qnan;
        logic              dbz;
        logic              infs;
        logic              zero;
        logic              diff;
    } fp_rnd_in_type;

    // Stage A: rounded and renormalised magnitude plus everything stage B needs.
    typedef struct packed {
        logic              sig;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] frac;
        logic [2:0]        rm;
        logic              inexact;
        logic              uf;
        logic              snan;
        logic              qnan;
        logic              dbz;
        logic              infs;
        logic              zero;
        logic              diff;
    } fp_rnd_pipe_reg_type_1;

    localparam fp_rnd_pipe_reg_type_1 init_fp_rnd_pipe_reg_1 = '0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } fp_rnd_pipe_reg_type_2;

    localparam fp_rnd_pipe_reg_type_2 init_fp_rnd_pipe_reg_2 = '0;

    // Round-up decision from guard/round/sticky; unknown modes fall back to RNE.
    function automatic logic fp_rnd_inc(
        input logic [2:0] rm,
        input logic       sig,
        input logic [2:0] grs,
        input logic       lsb
    );
        logic g;
        logic r;
        logic s;
        logic any;
        g   = grs[2];
        r   = grs[1];
        s   = grs[0];
        any = g | r | s;
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sig & any;
            RM_RUP:  return !sig & any;
            RM_RMM:  return g;
            default: return g & (r | s | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fp_rnd_pipe.sv
// Two-stage binary32 rounding/packing pipeline with valid/ready flow control:
// stage A rounds and renormalises, stage B resolves specials/overflow and packs.
module fp_rnd_pipe
    import fp_rnd_pipe_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  fp_rnd_in_type fp_rnd_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   result_o,
    output logic [4:0]    flags_o
);

    fp_rnd_pipe_reg_type_1 r_1_q;
    fp_rnd_pipe_reg_type_1 r_1_d;
    fp_rnd_pipe_reg_type_2 r_2_q;
    fp_rnd_pipe_reg_type_2 r_2_d;

    logic va_q;
    logic va_d;
    logic vb_q;
    logic vb_d;
    logic b_ready;
    logic a_ready;
    logic load_a;
    logic load_b;

    logic [2:0]        rm_a;
    logic              inc_a;
    logic [MANT_W-1:0] m_a;
    logic              expo_zero_a;
    logic              inexact_a;

    logic              ovf_b;
    logic              ovf_to_inf_b;
    logic              zero_sign_b;

    // Record width is shared with the binary64 path; these fields do not apply here.
    logic unused_fields;
    assign unused_fields = ^{fp_rnd_i.rema, fp_rnd_i.fmt};

    always_comb begin : ctrl
        b_ready = !vb_q || out_ready_i;
        a_ready = !va_q || b_ready;
        load_a  = a_ready && in_valid_i && !clear_i;
        load_b  = b_ready && va_q && !clear_i;
        va_d    = va_q;
        vb_d    = vb_q;
        if (clear_i) begin
            va_d = 1'b0;
            vb_d = 1'b0;
        end else begin
            if (b_ready) begin
                vb_d = va_q;
            end
            if (a_ready) begin
                va_d = in_valid_i;
            end
        end
    end

    always_comb begin : v_1
        r_1_d       = init_fp_rnd_pipe_reg_1;
        rm_a        = (fp_rnd_i.rm > RM_RMM) ? RM_RNE : fp_rnd_i.rm;
        inc_a       = fp_rnd_inc(rm_a, fp_rnd_i.sig, fp_rnd_i.grs, fp_rnd_i.mant[0]);
        m_a         = fp_rnd_i.mant + MANT_W'(inc_a);
        expo_zero_a = (fp_rnd_i.expo == '0);
        inexact_a   = |fp_rnd_i.grs;

        r_1_d.sig     = fp_rnd_i.sig;
        r_1_d.rm      = rm_a;
        r_1_d.inexact = inexact_a;
        // Tininess is judged on the unrounded exponent.
        r_1_d.uf      = expo_zero_a && inexact_a;
        r_1_d.snan    = fp_rnd_i.snan;
        r_1_d.qnan    = fp_rnd_i.qnan;
        r_1_d.dbz     = fp_rnd_i.dbz;
        r_1_d.infs    = fp_rnd_i.infs;
        r_1_d.zero    = fp_rnd_i.zero;
        r_1_d.diff    = fp_rnd_i.diff;

        if (m_a[MANT_W-1]) begin
            r_1_d.e    = fp_rnd_i.expo + EXP_W'(1);
            r_1_d.frac = m_a[MANT_W-2:1];
        end else if (expo_zero_a && m_a[MANT_W-2]) begin
            r_1_d.e    = EXP_W'(1);
            r_1_d.frac = m_a[FRAC_W-1:0];
        end else begin
            r_1_d.e    = fp_rnd_i.expo;
            r_1_d.frac = m_a[FRAC_W-1:0];
        end
    end

    always_comb begin : v_2
        r_2_d        = init_fp_rnd_pipe_reg_2;
        ovf_b        = (r_1_q.e >= EXP_OVF);
        ovf_to_inf_b = (r_1_q.rm == RM_RNE) || (r_1_q.rm == RM_RMM)
                    || ((r_1_q.rm == RM_RUP) && !r_1_q.sig)
                    || ((r_1_q.rm == RM_RDN) && r_1_q.sig);
        zero_sign_b  = r_1_q.diff ? (r_1_q.rm == RM_RDN) : r_1_q.sig;

        if (r_1_q.snan) begin
            r_2_d.result         = CANON_NAN;
            r_2_d.flags[FLAG_NV] = 1'b1;
        end else if (r_1_q.qnan) begin
            r_2_d.result = CANON_NAN;
        end else if (r_1_q.dbz) begin
            r_2_d.result         = {r_1_q.sig, EXP_INF, {FRAC_W{1'b0}}};
            r_2_d.flags[FLAG_DZ] = 1'b1;
        end else if (r_1_q.infs) begin
            r_2_d.result = {r_1_q.sig, EXP_INF, {FRAC_W{1'b0}}};
        end else if (r_1_q.zero) begin
            r_2_d.result = {zero_sign_b, 31'b0};
        end else if (ovf_b) begin
            r_2_d.result         = ovf_to_inf_b ? {r_1_q.sig, EXP_INF, {FRAC_W{1'b0}}}
                                                : {r_1_q.sig, MAX_FIN};
            r_2_d.flags[FLAG_OF] = 1'b1;
            r_2_d.flags[FLAG_NX] = 1'b1;
        end else begin
            r_2_d.result         = {r_1_q.sig, r_1_q.e[7:0], r_1_q.frac};
            r_2_d.flags[FLAG_UF] = r_1_q.uf;
            r_2_d.flags[FLAG_NX] = r_1_q.inexact;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
            r_1_q <= init_fp_rnd_pipe_reg_1;
            r_2_q <= init_fp_rnd_pipe_reg_2;
        end else begin
            va_q <= va_d;
            vb_q <= vb_d;
            if (load_a) begin
                r_1_q <= r_1_d;
            end
            if (load_b) begin
                r_2_q <= r_2_d;
            end
        end
    end

    assign in_ready_o  = a_ready;
    assign out_valid_o = vb_q;
    assign result_o    = r_2_q.result;
    assign flags_o     = r_2_q.flags;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe: table of rounding vectors plus flow-control,
// clear and asynchronous-reset sequences.
module tb_fp_rnd_pipe;
    import fp_rnd_pipe_pkg::*;

    typedef struct {
        string       name;
        logic        sig;
        logic [10:0] expo;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [5:0]  spc;   // {snan,qnan,dbz,infs,zero,diff}
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    localparam int NV = 26;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    fp_rnd_in_type rec;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic [4:0]    flags;

    vec_t vecs [NV];
    int   n_checks;
    int   n_fail;
    int   first_drop;
    int   n_out;
    int   fidx [4];
    int   lat;
    logic acc;
    logic got;

    fp_rnd_pipe dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .fp_rnd_i    (rec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .flags_o     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic sig, input logic [10:0] expo,
                                input logic [24:0] mant, input logic [2:0] grs,
                                input logic [2:0] rm, input logic [5:0] spc,
                                input logic [31:0] res, input logic [4:0] flg);
        vec_t v;
        v.name = nm; v.sig = sig; v.expo = expo; v.mant = mant; v.grs = grs;
        v.rm = rm; v.spc = spc; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rec      = '0;
        rec.sig  = v.sig;
        rec.expo = v.expo;
        rec.mant = v.mant;
        rec.grs  = v.grs;
        rec.rm   = v.rm;
        rec.rema = 2'b10;
        rec.fmt  = 2'b11;
        {rec.snan, rec.qnan, rec.dbz, rec.infs, rec.zero, rec.diff} = v.spc;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        vecs[0]  = mk("one",         0, 127, 25'h0800000, 3'b000, RM_RNE, 6'b000000, 32'h3F800000, 5'h00);
        vecs[1]  = mk("tie_rne",     0, 127, 25'h0FFFFFF, 3'b100, RM_RNE, 6'b000000, 32'h40000000, 5'h01);
        vecs[2]  = mk("tie_rtz",     0, 127, 25'h0FFFFFF, 3'b100, RM_RTZ, 6'b000000, 32'h3FFFFFFF, 5'h01);
        vecs[3]  = mk("ovf_rne",     0, 254, 25'h0FFFFFF, 3'b110, RM_RNE, 6'b000000, 32'h7F800000, 5'h05);
        vecs[4]  = mk("max_rtz",     0, 254, 25'h0FFFFFF, 3'b110, RM_RTZ, 6'b000000, 32'h7F7FFFFF, 5'h01);
        vecs[5]  = mk("ovf_rtz",     0, 255, 25'h0FFFFFF, 3'b110, RM_RTZ, 6'b000000, 32'h7F7FFFFF, 5'h05);
        vecs[6]  = mk("ovf_rdn_neg", 1, 254, 25'h0FFFFFF, 3'b110, RM_RDN, 6'b000000, 32'hFF800000, 5'h05);
        vecs[7]  = mk("ovf_rup_neg", 1, 255, 25'h0FFFFFF, 3'b110, RM_RUP, 6'b000000, 32'hFF7FFFFF, 5'h05);
        vecs[8]  = mk("sub_promote", 0, 0,   25'h07FFFFF, 3'b100, RM_RNE, 6'b000000, 32'h00800000, 5'h03);
        vecs[9]  = mk("sub_exact",   0, 0,   25'h0000001, 3'b000, RM_RNE, 6'b000000, 32'h00000001, 5'h00);
        vecs[10] = mk("sub_inexact", 0, 0,   25'h0000010, 3'b010, RM_RNE, 6'b000000, 32'h00000010, 5'h03);
        vecs[11] = mk("zero_d_rne",  0, 0,   25'h0000000, 3'b000, RM_RNE, 6'b000011, 32'h00000000, 5'h00);
        vecs[12] = mk("zero_d_rdn",  0, 0,   25'h0000000, 3'b000, RM_RDN, 6'b000011, 32'h80000000, 5'h00);
        vecs[13] = mk("zero_neg",    1, 0,   25'h0000000, 3'b000, RM_RNE, 6'b000010, 32'h80000000, 5'h00);
        vecs[14] = mk("snan",        0, 0,   25'h0000000, 3'b000, RM_RNE, 6'b100000, 32'h7FC00000, 5'h10);
        vecs[15] = mk("qnan",        1, 0,   25'h0000000, 3'b000, RM_RNE, 6'b010000, 32'h7FC00000, 5'h00);
        vecs[16] = mk("dbz_neg",     1, 0,   25'h0000000, 3'b000, RM_RNE, 6'b001000, 32'hFF800000, 5'h08);
        vecs[17] = mk("inf_pos",     0, 0,   25'h0000000, 3'b000, RM_RNE, 6'b000100, 32'h7F800000, 5'h00);
        vecs[18] = mk("snan_infs",   1, 0,   25'h0000000, 3'b000, RM_RNE, 6'b100100, 32'h7FC00000, 5'h10);
        vecs[19] = mk("rmm",         0, 127, 25'h0800000, 3'b100, RM_RMM, 6'b000000, 32'h3F800001, 5'h01);
        vecs[20] = mk("rne_even",    0, 127, 25'h0800000, 3'b100, RM_RNE, 6'b000000, 32'h3F800000, 5'h01);
        vecs[21] = mk("rup_pos",     0, 127, 25'h0800000, 3'b001, RM_RUP, 6'b000000, 32'h3F800001, 5'h01);
        vecs[22] = mk("rdn_pos",     0, 127, 25'h0800000, 3'b001, RM_RDN, 6'b000000, 32'h3F800000, 5'h01);
        vecs[23] = mk("rm7_as_rne",  0, 127, 25'h0800001, 3'b100, 3'd7,   6'b000000, 32'h3F800002, 5'h01);
        vecs[24] = mk("rdn_neg",     1, 127, 25'h0800000, 3'b001, RM_RDN, 6'b000000, 32'hBF800001, 5'h01);
        vecs[25] = mk("rne_up",      0, 127, 25'h0800000, 3'b110, RM_RNE, 6'b000000, 32'h3F800001, 5'h01);
        fidx[0] = 0; fidx[1] = 1; fidx[2] = 8; fidx[3] = 16;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Table: one record at a time, full-speed consumer.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
            chk({vecs[i].name, "_result"}, result, vecs[i].res);
            chk({vecs[i].name, "_flags"}, 32'(flags), 32'(vecs[i].flg));
            $display("vec %-12s result=%h flags=%b latency=%0d", vecs[i].name, result, flags, lat);
            @(posedge clk);
            #1;
        end

        // Flow control: 4 back-to-back records, consumer stalled for 3 cycles.
        first_drop = -1;
        n_out = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    drive(vecs[fidx[k]]);
                    in_valid = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 20 && !got; t++) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!acc && first_drop < 0) first_drop = k;
                        @(posedge clk);
                        #1;
                        got = acc;
                    end
                    if (!got) chk("flow_accept_timeout", 32'(k), 32'd99);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 40 && n_out < 4; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("flow_result", result, vecs[fidx[n_out]].res);
                        chk("flow_flags", 32'(flags), 32'(vecs[fidx[n_out]].flg));
                        if (out_ready) begin
                            $display("flow out %0d result=%h flags=%b", n_out, result, flags);
                            n_out++;
                        end
                    end
                end
            end
        join
        chk("flow_drop_after", 32'(first_drop), 32'd2);
        chk("flow_count", 32'(n_out), 32'd4);
        @(posedge clk);
        #1;

        // Clear drops both stages and ignores the simultaneous in_valid.
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("clr_pre_out_valid", 32'(out_valid), 32'd1);
        drive(vecs[2]);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid_0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("clr_out_valid_1", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        $display("clear sequence out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Asynchronous reset while a result is held.
        drive(vecs[16]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_result", result, 32'hFF800000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", 32'(flags), 32'd0);
        $display("async reset result=%h flags=%b out_valid=%0d", result, flags, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
